car_cmd_decoder: RTL and testbench
==================================

Name: car_cmd_decoder

Overview:
- Parses framed motion commands arriving as a byte stream from the car's UART receiver.
- Drives per-channel motor direction codes, a shared speed value and timed motion runs.
- Sits between the UART RX block and the PWM/motor driver blocks.
- Generalised instruction stage: channel count, timing unit and inter-byte timeout are parameters; adds checksum validation, timed runs and pre-emption.

Parameters:
- NUM_CH, 2, motor channel count. Even-indexed channels are the left side, odd-indexed the right side. Must be at least 2.
- UNIT_CYCLES, 1000000, clock cycles per duration unit.
- BYTE_TIMEOUT, 500000, maximum idle cycles between bytes of one frame.
- DEF_SPEED, 8'd128, speed value after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid when high
- motor_dir  out  2*NUM_CH  per-channel code: 00 stop, 01 forward, 10 reverse; channel i occupies bits [2i+1:2i]
- speed  out  8  current speed setting
- busy  out  1  high while a timed run is in progress
- cmd_ok  out  1  one-cycle pulse when a frame is accepted
- cmd_err  out  1  one-cycle pulse when a frame is rejected or times out

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: motor_dir=0, speed=DEF_SPEED, busy=0, cmd_ok=0, cmd_err=0, parser state P_HDR, all counters 0.
- Frame format: 4 bytes.
  - Byte 0: header 0xA5.
  - Byte 1: CMD.
  - Byte 2: ARG.
  - Byte 3: SUM, equal to CMD XOR ARG.
- Parser FSM: P_HDR -> P_CMD -> P_ARG -> P_SUM. Each transition occurs only on rx_valid.
- P_HDR:
  - Bytes other than 0xA5 are silently discarded; no cmd_err.
  - 0xA5 -> P_CMD.
- P_CMD and P_ARG: latch the byte and advance.
- P_SUM:
  - Checksum match and CMD in 0x00..0x05: cmd_ok pulses on the cycle after the SUM byte; command is executed; return to P_HDR.
  - Otherwise: cmd_err pulses on the cycle after the SUM byte; return to P_HDR; no state change.
- Inter-byte timeout:
  - A gap counter runs in P_CMD, P_ARG and P_SUM and clears on every rx_valid.
  - When it reaches BYTE_TIMEOUT: cmd_err pulses, parser returns to P_HDR, partial frame is dropped.
- Commands, with L = even channels and R = odd channels:
  - 0x00 STOP: all 00; busy=0; duration counter cleared.
  - 0x01 FWD: all 01.
  - 0x02 REV: all 10.
  - 0x03 LEFT: L=10, R=01.
  - 0x04 RIGHT: L=01, R=10.
  - 0x05 SPEED: speed<=ARG. motor_dir, busy and the run timer are unaffected.
- Duration for motion commands 0x01..0x04:
  - ARG=0: continuous. motor_dir holds until the next command; busy=0.
  - ARG>0: run for ARG*UNIT_CYCLES cycles. busy=1 from the cmd_ok cycle through the last run cycle. Then motor_dir<=0 and busy<=0 on the same edge.
  - Counter width must hold 255*UNIT_CYCLES without overflow.
- Latency: motor_dir and speed update on the same edge that raises cmd_ok, i.e. 1 cycle after the SUM strobe.
- Pre-emption: an accepted motion or STOP frame during a run replaces motor_dir and restarts or clears the timer immediately. A SPEED frame during a run leaves the timer running.
- Simultaneous events:
  - Timer expiry and a new accepted motion command on the same edge: the new command wins.
  - Timeout and rx_valid on the same cycle: rx_valid wins; the byte is consumed and the counter clears.
- Back-to-back frames with no gap are accepted at the full byte rate.
- A header byte arriving inside a frame is treated as data.
- Asserting rst mid-frame or mid-run returns every output to its reset value immediately, without waiting for clk.

Test Plan (UNIT_CYCLES=10, BYTE_TIMEOUT=50, NUM_CH=4):
- A5 01 03 02 -> cmd_ok 1 cycle after the SUM byte; motor_dir=8'b01010101; busy high for 30 cycles; then motor_dir=0, busy=0.
- A5 03 00 03 -> motor_dir=8'b01100110 (ch0/ch2=10, ch1/ch3=01); busy=0; state holds for 500 cycles.
- A5 05 40 45 during a FWD run with ARG=5 -> speed=0x40; run still ends 50 cycles after its own cmd_ok.
- A5 02 05 00 (bad SUM) -> cmd_err pulse; motor_dir and speed unchanged.
- A5 01, then 60 idle cycles -> cmd_err pulse at gap 50; the following A5 00 00 00 is accepted and all channels stop.
- Noise bytes 11 22 before a valid frame are ignored with no cmd_err. Asserting rst asynchronously mid-run forces motor_dir=0, busy=0, speed=0x80.

Source files
------------

// File: rtl/car_cmd_decoder.sv
// Framed motion-command decoder: parses A5/CMD/ARG/SUM frames from the UART byte stream
// and drives per-channel motor direction codes, a shared speed value and timed runs.
module car_cmd_decoder #(
    parameter int          NUM_CH       = 2,
    parameter int          UNIT_CYCLES  = 1000000,
    parameter int          BYTE_TIMEOUT = 500000,
    parameter logic [7:0]  DEF_SPEED    = 8'd128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [2*NUM_CH-1:0]   motor_dir,
    output logic [7:0]            speed,
    output logic                  busy,
    output logic                  cmd_ok,
    output logic                  cmd_err
);

    localparam int RUN_MAX = 255 * UNIT_CYCLES;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int GAP_W   = $clog2(BYTE_TIMEOUT + 1);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_TIMEOUT - 1);
    localparam logic [RUN_W-1:0] UNIT_V   = RUN_W'(UNIT_CYCLES);
    localparam logic [7:0]       HDR      = 8'hA5;

    typedef enum logic [1:0] {
        P_HDR,
        P_CMD,
        P_ARG,
        P_SUM
    } p_state_e;

    p_state_e               p_state_q, p_state_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [7:0]             arg_q, arg_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [RUN_W-1:0]       run_q, run_d;
    logic [2*NUM_CH-1:0]    motor_dir_q, motor_dir_d;
    logic [7:0]             speed_q, speed_d;
    logic                   busy_q, busy_d;
    logic                   cmd_ok_q, cmd_ok_d;
    logic                   cmd_err_q, cmd_err_d;

    logic [RUN_W-1:0]       run_load;
    logic                   sum_good;

    // Even channels form the left side, odd channels the right side.
    function automatic logic [2*NUM_CH-1:0] dir_pattern(input logic [7:0] cmd);
        logic [1:0]          l_code;
        logic [1:0]          r_code;
        logic [2*NUM_CH-1:0] pat;
        l_code = 2'b00;
        r_code = 2'b00;
        pat    = '0;
        case (cmd)
            8'h01:   begin l_code = 2'b01; r_code = 2'b01; end
            8'h02:   begin l_code = 2'b10; r_code = 2'b10; end
            8'h03:   begin l_code = 2'b10; r_code = 2'b01; end
            8'h04:   begin l_code = 2'b01; r_code = 2'b10; end
            default: begin l_code = 2'b00; r_code = 2'b00; end
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            pat[2*i +: 2] = (i % 2 == 0) ? l_code : r_code;
        end
        return pat;
    endfunction

    assign run_load = RUN_W'(arg_q) * UNIT_V;
    assign sum_good = (rx_data == (cmd_q ^ arg_q)) && (cmd_q <= 8'h05);

    always_comb begin
        p_state_d   = p_state_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        gap_d       = gap_q;
        run_d       = run_q;
        motor_dir_d = motor_dir_q;
        speed_d     = speed_q;
        busy_d      = busy_q;
        cmd_ok_d    = 1'b0;
        cmd_err_d   = 1'b0;

        // Run timer first so that an accepted command below overrides an expiry on the same edge.
        if (busy_q) begin
            if (run_q == RUN_W'(1)) begin
                busy_d      = 1'b0;
                motor_dir_d = '0;
                run_d       = '0;
            end else begin
                run_d = run_q - RUN_W'(1);
            end
        end

        if (rx_valid) begin
            gap_d = '0;
            case (p_state_q)
                P_HDR: begin
                    if (rx_data == HDR) p_state_d = P_CMD;
                end
                P_CMD: begin
                    cmd_d     = rx_data;
                    p_state_d = P_ARG;
                end
                P_ARG: begin
                    arg_d     = rx_data;
                    p_state_d = P_SUM;
                end
                default: begin
                    p_state_d = P_HDR;
                    if (sum_good) begin
                        cmd_ok_d = 1'b1;
                        case (cmd_q)
                            8'h00: begin
                                motor_dir_d = '0;
                                busy_d      = 1'b0;
                                run_d       = '0;
                            end
                            8'h05: begin
                                speed_d = arg_q;
                            end
                            default: begin
                                motor_dir_d = dir_pattern(cmd_q);
                                busy_d      = (arg_q != 8'h00);
                                run_d       = run_load;
                            end
                        endcase
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            endcase
        end else if (p_state_q != P_HDR) begin
            // A received byte on the same cycle takes priority over the gap limit (handled above).
            if (gap_q == GAP_LAST) begin
                cmd_err_d = 1'b1;
                p_state_d = P_HDR;
                gap_d     = '0;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state_q   <= P_HDR;
            cmd_q       <= 8'h00;
            arg_q       <= 8'h00;
            gap_q       <= '0;
            run_q       <= '0;
            motor_dir_q <= '0;
            speed_q     <= DEF_SPEED;
            busy_q      <= 1'b0;
            cmd_ok_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            p_state_q   <= p_state_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            gap_q       <= gap_d;
            run_q       <= run_d;
            motor_dir_q <= motor_dir_d;
            speed_q     <= speed_d;
            busy_q      <= busy_d;
            cmd_ok_q    <= cmd_ok_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign motor_dir = motor_dir_q;
    assign speed     = speed_q;
    assign busy      = busy_q;
    assign cmd_ok    = cmd_ok_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_car_cmd_decoder.sv
// Bench for car_cmd_decoder: directed and randomized byte streams checked every cycle
// against a frame-level reference model of the command rules.
module tb_car_cmd_decoder;

    localparam int         NUM_CH  = 4;
    localparam int         UNIT    = 10;
    localparam int         TMO     = 50;
    localparam logic [7:0] DEF_SPD = 8'd128;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic [2*NUM_CH-1:0]  motor_dir;
    logic [7:0]           speed;
    logic                 busy;
    logic                 cmd_ok;
    logic                 cmd_err;

    car_cmd_decoder #(
        .NUM_CH      (NUM_CH),
        .UNIT_CYCLES (UNIT),
        .BYTE_TIMEOUT(TMO),
        .DEF_SPEED   (DEF_SPD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .motor_dir(motor_dir),
        .speed    (speed),
        .busy     (busy),
        .cmd_ok   (cmd_ok),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: bytes of the frame in progress, idle gap, commanded motion.
    logic [7:0] frame_q[$];
    int         gap;
    logic [7:0] m_dir;
    bit         m_timed;
    int         m_end;
    logic [7:0] m_speed;
    bit         exp_ok;
    bit         exp_err;

    function automatic logic [7:0] dir_of(input logic [7:0] c);
        case (c)
            8'h01:   return 8'h55;
            8'h02:   return 8'hAA;
            8'h03:   return 8'b01100110;
            8'h04:   return 8'b10011001;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        frame_q.delete();
        gap     = 0;
        m_dir   = 8'h00;
        m_timed = 1'b0;
        m_end   = 0;
        m_speed = DEF_SPD;
        exp_ok  = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic execute(input logic [7:0] c, input logic [7:0] a);
        if (c == 8'h00) begin
            m_dir   = 8'h00;
            m_timed = 1'b0;
        end else if (c == 8'h05) begin
            m_speed = a;
        end else begin
            m_dir   = dir_of(c);
            m_timed = (a != 8'h00);
            m_end   = cyc + int'(a) * UNIT;
        end
    endtask

    // Applies what the DUT sampled on the edge just passed.
    task automatic model_edge(input bit v, input logic [7:0] d);
        logic [7:0] c;
        logic [7:0] a;
        logic [7:0] s;
        exp_ok  = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            gap = 0;
            if (frame_q.size() == 0) begin
                if (d == 8'hA5) frame_q.push_back(d);
            end else begin
                frame_q.push_back(d);
                if (frame_q.size() == 4) begin
                    c = frame_q[1];
                    a = frame_q[2];
                    s = frame_q[3];
                    frame_q.delete();
                    if (s == (c ^ a) && c <= 8'h05) begin
                        exp_ok = 1'b1;
                        execute(c, a);
                    end else begin
                        exp_err = 1'b1;
                    end
                end
            end
        end else if (frame_q.size() > 0) begin
            gap++;
            if (gap == TMO) begin
                exp_err = 1'b1;
                frame_q.delete();
                gap = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] e_dir;
        bit         e_busy;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(rx_valid, rx_data);
        e_busy = m_timed && (cyc < m_end);
        e_dir  = (m_timed && cyc >= m_end) ? 8'h00 : m_dir;
        chk("motor_dir", 32'(motor_dir), 32'(e_dir));
        chk("speed",     32'(speed),     32'(m_speed));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("cmd_ok",    32'(cmd_ok),    32'(exp_ok));
        chk("cmd_err",   32'(cmd_err),   32'(exp_err));
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] c,
                              input logic [7:0] a, input logic [7:0] s);
        send_byte(h);
        send_byte(c);
        send_byte(a);
        send_byte(s);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dir"},   32'(motor_dir), 32'(0));
        chk({tag, "_speed"}, 32'(speed),     32'(DEF_SPD));
        chk({tag, "_busy"},  32'(busy),      32'(0));
        chk({tag, "_ok"},    32'(cmd_ok),    32'(0));
        chk({tag, "_err"},   32'(cmd_err),   32'(0));
    endtask

    logic [7:0] rc, ra, rs;
    logic [7:0] fb[4];

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        #2;
        chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // Noise ahead of a timed forward run of 3 units.
        send_byte(8'h11);
        send_byte(8'h22);
        send_frame(8'hA5, 8'h01, 8'h03, 8'h02);
        idle(35);

        // Continuous LEFT turn holds.
        send_frame(8'hA5, 8'h03, 8'h00, 8'h03);
        idle(500);

        // SPEED frame in the middle of a 5-unit run leaves the run length alone.
        send_frame(8'hA5, 8'h01, 8'h05, 8'h04);
        idle(10);
        send_frame(8'hA5, 8'h05, 8'h40, 8'h45);
        idle(50);

        // Bad checksum and out-of-range command.
        send_frame(8'hA5, 8'h02, 8'h05, 8'h00);
        idle(3);
        send_frame(8'hA5, 8'h06, 8'h00, 8'h06);
        idle(3);

        // Partial frame abandoned, then STOP accepted.
        send_frame(8'hA5, 8'h02, 8'h00, 8'h02);
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(60);
        send_frame(8'hA5, 8'h00, 8'h00, 8'h00);
        idle(3);

        // Pre-emption of a run by another timed run, back to back with no gap.
        send_frame(8'hA5, 8'h01, 8'h02, 8'h03);
        send_frame(8'hA5, 8'h02, 8'h01, 8'h03);
        idle(15);

        // Expiry and a new continuous command land on the same edge.
        send_frame(8'hA5, 8'h04, 8'h01, 8'h05);
        idle(6);
        send_frame(8'hA5, 8'h02, 8'h00, 8'h02);
        idle(5);

        // Header value as CMD/ARG data, then STOP cuts the long run.
        send_frame(8'hA5, 8'h04, 8'hA5, 8'hA1);
        idle(20);
        send_frame(8'hA5, 8'hA5, 8'h00, 8'hA5);
        send_frame(8'hA5, 8'h00, 8'h00, 8'h00);
        idle(3);

        // A byte on the cycle the gap limit would fire is consumed.
        send_byte(8'hA5);
        idle(TMO - 1);
        send_byte(8'h01);
        idle(TMO - 1);
        send_byte(8'h00);
        idle(TMO - 1);
        send_byte(8'h01);
        idle(3);

        // Randomized frames, noise, gaps and occasional mid-frame timeouts.
        for (int f = 0; f < 40; f++) begin
            rc = 8'($urandom_range(0, 6));
            ra = 8'($urandom_range(0, 4));
            rs = rc ^ ra;
            if ($urandom_range(0, 4) == 0) rs = rs ^ 8'h01;
            if ($urandom_range(0, 5) == 0) send_byte(8'($urandom_range(0, 255)));
            fb[0] = 8'hA5;
            fb[1] = rc;
            fb[2] = ra;
            fb[3] = rs;
            for (int k = 0; k < 4; k++) begin
                send_byte(fb[k]);
                if (k < 3) idle(($urandom_range(0, 11) == 0) ? 52 : int'($urandom_range(0, 3)));
            end
            idle(int'($urandom_range(0, 40)));
        end

        // Asynchronous reset in the middle of a run.
        send_frame(8'hA5, 8'h05, 8'h33, 8'h36);
        send_frame(8'hA5, 8'h01, 8'h05, 8'h04);
        idle(7);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        model_reset();
        idle(3);
        send_frame(8'hA5, 8'h02, 8'h00, 8'h02);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
